gpio_debounce: RTL and testbench
================================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: DIV, 1000, prescaler period in clk cycles between sample ticks (legal range >= 1).
REQ-003 Parameter: STABLE, 4, number of consecutive differing sample ticks required to accept a new level (legal range >= 1).
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: en  input  1  debounce enable.
REQ-007 Port: pinIn  input  16  raw, asynchronous pad levels.
REQ-008 Port: debOut  output  16  debounced levels; drives the gpioInput port of the gpio peripheral.
REQ-009 Port: rise  output  16  per-bit one-cycle pulse on a debounced 0->1 transition.
REQ-010 Port: fall  output  16  per-bit one-cycle pulse on a debounced 1->0 transition.
REQ-011 Port: anyEdge  output  1  OR-reduction of rise and fall.

Function
REQ-012 Each pinIn bit SHALL pass through a 2-flop synchronizer; "sync" below means the second-stage output.
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap to 0; tick is asserted for the one cycle in which the count equals DIV-1.
REQ-014 With DIV=1, tick SHALL be asserted on every cycle.
REQ-015 Each bit SHALL own a saturating counter of width max(1, clog2(STABLE)).
REQ-016 On a tick, a bit whose sync equals its debOut SHALL clear its counter.
REQ-017 On a tick, a bit whose sync differs from its debOut and whose counter is below STABLE-1 SHALL increment its counter.
REQ-018 On a tick, a bit whose sync differs from its debOut and whose counter equals STABLE-1 SHALL toggle debOut and clear its counter in the same edge.
REQ-019 No counter and no debOut bit SHALL change on a non-tick cycle.
REQ-020 Each bit SHALL be processed independently; any number of bits MAY update on the same tick.
REQ-021 Glitch rule: any tick with sync equal to debOut before acceptance restarts the qualification from zero.
REQ-022 Latency from a stable pinIn change to debOut SHALL be 2 synchronizer cycles plus the time to reach the STABLE-th qualifying tick, i.e. at most 2 + STABLE*DIV cycles.
REQ-023 rise[i] and fall[i] SHALL be registered and asserted for exactly the cycle in which the new debOut[i] value is first visible; anyEdge SHALL be asserted in that same cycle.
REQ-024 While en=0, the prescaler SHALL be held at 0, no ticks SHALL occur, all counters SHALL be cleared, and debOut SHALL hold its value; the synchronizer SHALL keep running.
REQ-025 On en 0->1, the first tick SHALL occur DIV cycles later.

Reset
REQ-026 rst_n low SHALL asynchronously clear the synchronizer flops, prescaler, counters, debOut, rise, fall and anyEdge to 0.
REQ-027 A reset asserted mid-qualification SHALL discard all partial counts; after release, a pin held at 1 SHALL re-qualify from zero.
REQ-028 The reset value debOut=0 SHALL match the reset value of the downstream gpio input register.

Configuration
REQ-029 Macro GPIO_DEBOUNCE_EDGE_EN defined: rise, fall and anyEdge SHALL behave per REQ-023.
REQ-030 Macro GPIO_DEBOUNCE_EDGE_EN undefined: rise, fall and anyEdge ports SHALL remain present, be tied to constant 0, and generate no edge-detect flops; debOut behaviour SHALL be unchanged.

Verification
REQ-031 Settle: DIV=4, STABLE=3, pinIn[0] 0->1 held -> debOut[0]=1 no later than 14 cycles after the change; rise[0] high for exactly 1 cycle; anyEdge high in the same cycle.
REQ-032 Glitch: DIV=4, STABLE=3, pinIn[5] high for 2 ticks then low -> debOut[5] stays 0; rise and anyEdge never assert.
REQ-033 Multi-bit: pinIn 0x0000 -> 0xA5A5 at one instant -> debOut=0xA5A5 on a single edge; rise=0xA5A5 for 1 cycle. Then pinIn -> 0x0000 -> fall=0xA5A5 for 1 cycle.
REQ-034 Enable: en=0 while pinIn[3]=1 for 100 cycles -> debOut[3] stays 0. After en=1 -> debOut[3]=1 within DIV*STABLE+DIV cycles.
REQ-035 Reset mid-op: rst_n pulsed low after 2 qualifying ticks with pinIn[7]=1 -> all outputs 0 immediately; after release, the full STABLE ticks are needed again.
REQ-036 Macro off: repeat REQ-031 -> debOut[0] matches; rise, fall and anyEdge stay 0 throughout.

Source files
------------

// File: rtl/gpio_debounce.sv
// gpio_debounce: 16-bit pad synchronizer with a prescaled, per-bit saturating-counter debouncer.
// Define GPIO_DEBOUNCE_EDGE_EN to build the registered rise/fall/anyEdge pulses; otherwise they are tied low.
module gpio_debounce #(
  parameter int DIV    = 1000,
  parameter int STABLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pinIn,
  output logic [15:0] debOut,
  output logic [15:0] rise,
  output logic [15:0] fall,
  output logic        anyEdge
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = STABLE > 1 ? $clog2(STABLE) : 1;
  logic [15:0]   meta, sync, accept;
  logic [PW-1:0] pre;
  logic [CW-1:0] cnt [16];
  logic          tick;
  assign tick = en && pre == PW'(DIV - 1);
  // A bit flips on the STABLE-th consecutive tick that disagrees with debOut.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 16; i++)
      accept[i] = tick && sync[i] != debOut[i] && cnt[i] == CW'(STABLE - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      pre  <= '0;
    end else begin
      meta <= pinIn;
      sync <= meta;
      pre  <= (!en || tick) ? '0 : pre + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      debOut <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      debOut <= debOut ^ accept;
      for (int i = 0; i < 16; i++)
        cnt[i] <= (!en || accept[i] || (tick && sync[i] == debOut[i])) ? '0 :
                  tick ? cnt[i] + 1'b1 : cnt[i];
    end
`ifdef GPIO_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rise    <= '0;
      fall    <= '0;
      anyEdge <= 1'b0;
    end else begin
      rise    <= accept & ~debOut;
      fall    <= accept & debOut;
      anyEdge <= |accept;
    end
`else
  assign rise    = '0;
  assign fall    = '0;
  assign anyEdge = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: randomized scoreboard bench; a tick-index reference model predicts every debounced change.
module tb_gpio_debounce;
  localparam int DIV = 4, STABLE = 3;
`ifdef GPIO_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [15:0] pinIn = '0, debOut, rise, fall;
  logic        anyEdge;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct { int cyc; logic [15:0] deb, r, f; } ev_t;
  ev_t sb[$];

  gpio_debounce #(.DIV(DIV), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pinIn(pinIn),
    .debOut(debOut), .rise(rise), .fall(fall), .anyEdge(anyEdge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a bit accepts a new level once STABLE ticks have elapsed since the
  // last tick that reset its qualification (agreeing sample, acceptance, enable low or reset).
  logic [15:0] mDeb = '0, p1 = '0, p2 = '0;
  int run = 0, tickIdx = 0;
  int mark [16];
  initial foreach (mark[i]) mark[i] = 0;
  always @(posedge clk) begin
    logic [15:0] s, acc;
    cyc++;
    acc = '0;
    if (!rst_n) begin
      mDeb = '0; p1 = '0; p2 = '0; run = 0; tickIdx = 0;
      foreach (mark[i]) mark[i] = 0;
    end else begin
      s = p2; p2 = p1; p1 = pinIn;
      run = en ? run + 1 : 0;
      if (!en) foreach (mark[i]) mark[i] = tickIdx;
      else if (run % DIV == 0) begin
        tickIdx++;
        for (int i = 0; i < 16; i++)
          if (s[i] == mDeb[i]) mark[i] = tickIdx;
          else if (tickIdx - mark[i] >= STABLE) begin
            acc[i] = 1'b1;
            mark[i] = tickIdx;
          end
      end
      if (acc != 0) begin
        sb.push_back('{cyc, mDeb ^ acc, EDGE ? (acc & ~mDeb) : 16'h0, EDGE ? (acc & mDeb) : 16'h0});
        mDeb ^= acc;
      end
    end
  end

  // Monitor: any visible output activity must match the oldest predicted event.
  logic [15:0] prevDeb = '0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) prevDeb = '0;
    else if (debOut != prevDeb || anyEdge || rise != 0 || fall != 0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: debOut=%h rise=%h fall=%h anyEdge=%b with no prediction (cycle %0d)",
                 debOut, rise, fall, anyEdge, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("debOut", {16'h0, debOut}, {16'h0, e.deb});
        chk("rise", {16'h0, rise}, {16'h0, e.r});
        chk("fall", {16'h0, fall}, {16'h0, e.f});
        chk("anyEdge", {31'h0, anyEdge}, {31'h0, |(e.r | e.f)});
      end
      prevDeb = debOut;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_debOut", {16'h0, debOut}, 0);
    chk("reset_rise", {16'h0, rise}, 0);
    chk("reset_fall", {16'h0, fall}, 0);
    chk("reset_anyEdge", {31'h0, anyEdge}, 0);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    pinIn[0] = 1'b1;
    repeat (14) @(negedge clk);
    chk("settle_deb0", {31'h0, debOut[0]}, 1);
    repeat (10) @(negedge clk);
    pinIn[5] = 1'b1;
    repeat (8) @(negedge clk);
    pinIn[5] = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_deb5", {31'h0, debOut[5]}, 0);
    pinIn = '0;
    repeat (30) @(negedge clk);
    pinIn = 16'hA5A5;
    repeat (30) @(negedge clk);
    chk("multi_set", {16'h0, debOut}, 32'hA5A5);
    pinIn = '0;
    repeat (30) @(negedge clk);
    chk("multi_clr", {16'h0, debOut}, 0);
    en = 1'b0;
    pinIn[3] = 1'b1;
    repeat (100) @(negedge clk);
    chk("en_hold_deb3", {31'h0, debOut[3]}, 0);
    en = 1'b1;
    repeat (DIV * STABLE + DIV) @(negedge clk);
    chk("en_release_deb3", {31'h0, debOut[3]}, 1);
    pinIn[7] = 1'b1;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_debOut", {16'h0, debOut}, 0);
    chk("midrst_rise", {16'h0, rise}, 0);
    chk("midrst_fall", {16'h0, fall}, 0);
    chk("midrst_anyEdge", {31'h0, anyEdge}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (11) @(negedge clk);
    chk("requal_early_deb7", {31'h0, debOut[7]}, 0);
    @(negedge clk);
    chk("requal_done_deb7", {31'h0, debOut[7]}, 1);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      pinIn = ($urandom_range(0, 2) == 0) ? 16'($urandom) : pinIn ^ (16'h1 << $urandom_range(0, 15));
      en = $urandom_range(0, 7) != 0;
      repeat ($urandom_range(1, 24)) @(negedge clk);
    end
    en = 1'b1;
    repeat (40) @(negedge clk);
    chk("final_debOut", {16'h0, debOut}, {16'h0, mDeb});
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
